lsu_bridge: RTL and testbench
=============================

# lsu_bridge

Load/store bridge between the single-cycle RV32 core's combinational data-memory port and a pipelined request/grant/response data bus. It accepts one word access per instruction, holds it on the bus until granted, and captures the read response. It returns a stall to the core's program-counter enable so the instruction retires only when the access has completed. It sits directly downstream of the core's mem_we_o/mem_addr_o/mem_data_o/mem_data_i port.

## Interface
Parameters:
- XLEN, 32, data/address width
- TIMEOUT, 255, maximum cycles in WAIT_GNT or WAIT_RSP before the access is aborted with an error

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- mem_we_i  in  1  core store strobe
- mem_re_i  in  1  core load strobe (opcode LOAD decode); never high together with mem_we_i
- mem_addr_i  in  XLEN  core byte address (ALU result)
- mem_data_i  in  XLEN  core store data
- mem_data_o  out  XLEN  load data returned to core result mux
- stall_o  out  1  high = core must hold PC and suppress register write
- err_o  out  1  sticky error: misaligned access, bus error or timeout
- bus_req_o  out  1  request valid
- bus_we_o  out  1  request is a write
- bus_addr_o  out  XLEN  word-aligned address, bits [1:0] = 0
- bus_wdata_o  out  XLEN  write data
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  response valid; required for reads and writes
- bus_rdata_i  in  XLEN  read data
- bus_err_i  in  1  response error, qualified by bus_rvalid_i

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RSP, DONE.
- IDLE: when (mem_we_i | mem_re_i) is high, latch we/addr/wdata. If addr[1:0] != 0, set err_o, go to DONE, and issue no bus request. Otherwise go to WAIT_GNT.
- WAIT_GNT: bus_req_o = 1, with address/data from the latched registers. On bus_gnt_i, go to WAIT_RSP.
- WAIT_RSP: on bus_rvalid_i, capture bus_rdata_i into the rdata register (loads only), OR bus_err_i into err_o, and go to DONE.
- DONE: stall_o = 0 for exactly one cycle; mem_data_o = captured rdata. Unconditionally return to IDLE.
- stall_o is combinational: it equals (mem_we_i | mem_re_i) in IDLE, 1 in WAIT_GNT and WAIT_RSP, and 0 in DONE. Non-memory instructions are never stalled.
- Timeout counter (clog2(TIMEOUT+1) bits):
  - cleared on every state change;
  - increments in WAIT_GNT and WAIT_RSP;
  - on reaching TIMEOUT: set err_o, drop the request, go to DONE, and return rdata = 0.
- After a misaligned access, error or timeout, DONE returns rdata = 0 and the store is discarded.
- err_o clears only on reset.
- A request is held stable while bus_req_o=1 and gnt=0: the address, write flag and data must not change.

## Timing
- Reset values (asynchronous assert, synchronous release): state = IDLE, bus_req_o = 0, bus_we_o = 0, bus_addr_o = 0, bus_wdata_o = 0, mem_data_o = 0, err_o = 0, counter = 0. stall_o follows its combinational rule.
- Minimum access latency, with gnt in the first request cycle and rvalid the cycle after: IDLE(t) → WAIT_GNT(t+1) → WAIT_RSP(t+2) → DONE(t+3). The core stalls for cycles t..t+2 and retires at the end of t+3.
- bus_gnt_i and bus_rvalid_i may be high in the same cycle. The grant is taken first; rvalid is honoured only in WAIT_RSP. A response arriving in WAIT_GNT is ignored.
- An rvalid in IDLE or DONE is ignored; no state change.
- A reset mid-access aborts it immediately and leaves no pending request. An in-flight bus response after reset is ignored.
- Back-to-back accesses: DONE → IDLE inserts one idle bus cycle between requests.

## Structure
- Shared package rv32_pkg: the lsu_state_t enum (IDLE, WAIT_GNT, WAIT_RSP, DONE) and the OP_LOAD/OP_STORE opcode constants used by ctrl_unit to drive mem_re_i.
- Single module; no sub-module. Timeout counter inline.
- Top-level integration: stall_o drives ~en of the program counter, and gates the core's register-file write enable.

## Test plan
- Aligned load, addr 0x100, gnt in the first cycle, rvalid+rdata 0xDEADBEEF the next cycle → stall_o high for 3 cycles; mem_data_o = 0xDEADBEEF in DONE; err_o = 0.
- Store addr 0x204, data 0x12345678, gnt withheld for 5 cycles → bus_req_o/addr/wdata stable throughout, bus_we_o = 1; completes on rvalid; one DONE cycle.
- Load addr 0x102 (misaligned) → no bus_req_o; DONE the next cycle with rdata 0; err_o = 1 and sticky.
- TIMEOUT = 4, gnt never asserted → abort after 4 WAIT_GNT cycles; bus_req_o drops; DONE with err_o = 1.
- rst_i pulsed low during WAIT_RSP, then a stale rvalid → all outputs at reset values; rvalid ignored; the next load completes normally.
- Non-memory instruction stream (we=re=0) → stall_o = 0 every cycle; bus_req_o = 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// ============================================================================
// Module   : rv32_pkg
// Purpose  : Shared RV32 core types: LSU bridge states and memory opcodes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_t;

  // Major opcodes decoded by ctrl_unit to raise mem_re_i / mem_we_i.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

`default_nettype wire

// File: rtl/lsu_bridge.sv
// ============================================================================
// Module   : lsu_bridge
// Purpose  : Single-cycle core data port to pipelined req/gnt/rsp bus bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_bridge
  import rv32_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_we_i,
  input  logic            mem_re_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic [XLEN-1:0] mem_data_o,
  output logic            stall_o,
  output logic            err_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_gnt_i,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  input  logic            bus_err_i
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  lsu_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-3:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            access;

  assign access = mem_we_i | mem_re_i;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall_o = access;
        if (access) begin
          we_d    = mem_we_i;
          addr_d  = mem_addr_i[XLEN-1:2];
          wdata_d = mem_data_i;
          rdata_d = '0;
          if (mem_addr_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        stall_o = 1'b1;
        // A grant in the final allowed cycle still wins over the timeout.
        if (bus_gnt_i) begin
          state_d = WAIT_RSP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_RSP: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) begin
          if (!we_q && !bus_err_i) begin
            rdata_d = bus_rdata_i;
          end
          err_d   = err_q | bus_err_i;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == WAIT_GNT || state_q == WAIT_RSP) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_req_o   = (state_q == WAIT_GNT);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q, 2'b00};
  assign bus_wdata_o = wdata_q;
  assign mem_data_o  = rdata_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bridge.sv
// ============================================================================
// Module   : tb_lsu_bridge
// Purpose  : Randomized scoreboard bench for lsu_bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_bridge;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 255;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            mem_we_i = 1'b0, mem_re_i = 1'b0;
  logic [XLEN-1:0] mem_addr_i = '0, mem_data_i = '0;
  logic [XLEN-1:0] mem_data_o;
  logic            stall_o, err_o;
  logic            bus_req_o, bus_we_o;
  logic [XLEN-1:0] bus_addr_o, bus_wdata_o;
  logic            bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
  logic [XLEN-1:0] bus_rdata_i = '0;

  lsu_bridge #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .stall_o(stall_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int g; int r; logic [31:0] rdata; logic berr; logic glitch; } plan_t;
  typedef struct { int kind; int stalls; logic [31:0] data; logic chk_data; logic err; } exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  req_t  req_q[$];

  int   n_checks  = 0;
  int   n_errors  = 0;
  logic model_err = 1'b0;
  logic mon_en    = 1'b0;
  logic resp_en   = 1'b1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave model: grants and responds per the plan of each aligned access.
  initial begin
    plan_t p;
    forever begin
      @(negedge clk_i); #1;
      if (resp_en) begin
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        if (bus_req_o && plan_q.size() > 0) begin
          p = plan_q.pop_front();
          if (p.g >= TIMEOUT) begin
            for (int k = 0; k < 100 && bus_req_o; k++) begin
              @(negedge clk_i); #1;
            end
          end else begin
            repeat (p.g) begin @(negedge clk_i); #1; end
            bus_gnt_i = 1'b1;
            if (p.glitch) begin
              bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5A5A_0BAD; bus_err_i = 1'b1;
            end
            @(negedge clk_i); #1;
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
            repeat (p.r) begin @(negedge clk_i); #1; end
            bus_rvalid_i = 1'b1; bus_rdata_i = p.rdata; bus_err_i = p.berr;
            @(negedge clk_i); #1;
            bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
          end
        end else if ($urandom_range(7) == 0) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = $urandom; bus_err_i = 1'b1;
        end
      end
    end
  end

  // Retirement monitor: an instruction retires on a cycle with stall_o low.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk_i); #2;
      if (mon_en) begin
        if (stall_o) begin
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("err_o", {31'd0, err_o}, {31'd0, e.err});
          if (e.chk_data) chk("load_data", mem_data_o, e.data);
          if (e.kind == 0) chk("nonmem_req", {31'd0, bus_req_o}, 32'd0);
          stall_cnt = 0;
        end
      end
    end
  end

  // Bus request monitor: request fields must match and stay stable until accepted.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_i); #2;
      if (mon_en) begin
        if (bus_req_o) begin
          if (req_q.size() == 0) begin
            chk("req_unexpected", 32'd1, 32'd0);
          end else begin
            chk("bus_addr", bus_addr_o, req_q[0].addr);
            chk("bus_we", {31'd0, bus_we_o}, {31'd0, req_q[0].we});
            if (req_q[0].we) chk("bus_wdata", bus_wdata_o, req_q[0].wdata);
          end
          prev_req = 1'b1;
        end else if (prev_req) begin
          if (req_q.size() > 0) void'(req_q.pop_front());
          prev_req = 1'b0;
        end
      end
    end
  end

  // kind: 0 = non-memory, 1 = load, 2 = store; g = NEVER withholds the grant.
  task automatic issue(int kind, logic [31:0] addr, logic [31:0] data, int g, int r,
                       logic [31:0] rd, logic berr, logic glitch);
    exp_t  e;
    plan_t p;
    req_t  q;
    int    guard;
    e.kind = kind; e.chk_data = (kind == 1); e.data = 32'd0; e.stalls = 0;
    if (kind != 0 && addr[1:0] != 2'b00) begin
      e.stalls  = 1;
      model_err = 1'b1;
    end else if (kind != 0) begin
      p.g = g; p.r = r; p.rdata = rd; p.berr = berr; p.glitch = glitch;
      plan_q.push_back(p);
      q.we = (kind == 2); q.addr = addr; q.wdata = data;
      req_q.push_back(q);
      if (g >= TIMEOUT) begin
        e.stalls  = 1 + TIMEOUT;
        model_err = 1'b1;
      end else begin
        e.stalls = g + r + 3;
        if (kind == 1 && !berr) e.data = rd;
        if (berr) model_err = 1'b1;
      end
    end
    e.err = model_err;
    exp_q.push_back(e);
    @(negedge clk_i);
    mem_re_i = (kind == 1); mem_we_i = (kind == 2);
    mem_addr_i = addr; mem_data_i = data;
    mon_en = 1'b1;
    guard = 0;
    forever begin
      #3;
      if (!stall_o) break;
      guard++;
      if (guard > 200) begin
        n_errors++;
        $display("FAIL retire_timeout: stall_o stuck high, got 1 expected 0");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          kind;

    // Reset values while reset is held.
    repeat (2) @(negedge clk_i);
    chk("rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_we", {31'd0, bus_we_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    chk("rst_rdata", mem_data_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    rst_i = 1'b1;

    issue(1, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    issue(2, 32'h204, 32'h12345678, 5, 1, 32'h0, 1'b0, 1'b0);
    issue(0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
    issue(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1'b0, 1'b0);
    issue(1, 32'h180, 32'h0, 0, 0, 32'h0BAD_CAFE, 1'b0, 1'b1);
    issue(1, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
    issue(1, 32'h104, 32'h0, 2, 2, 32'h600D_DA7A, 1'b0, 1'b0);
    issue(1, 32'h108, 32'h0, NEVER, 0, 32'h1111_1111, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(2));
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) a = a | 32'($urandom_range(3, 1));
      issue(kind, a, $urandom,
            ($urandom_range(9) == 0) ? NEVER : int'($urandom_range(3)),
            int'($urandom_range(3)), $urandom,
            ($urandom_range(7) == 0), $urandom_range(1) == 1);
    end

    // Reset asserted in WAIT_RSP, then a stale response.
    mon_en = 1'b0;
    resp_en = 1'b0;
    @(negedge clk_i);
    mem_re_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk_i); #1 bus_gnt_i = 1'b1;
    @(negedge clk_i); #1 bus_gnt_i = 1'b0;
    chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    chk("pre_rst_req", {31'd0, bus_req_o}, 32'd0);
    rst_i = 1'b0;
    mem_re_i = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("mid_rst_we", {31'd0, bus_we_o}, 32'd0);
    chk("mid_rst_addr", bus_addr_o, 32'd0);
    chk("mid_rst_rdata", mem_data_o, 32'd0);
    chk("mid_rst_err", {31'd0, err_o}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBADBAD00; bus_err_i = 1'b1;
    @(negedge clk_i); #1 bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    chk("stale_stall", {31'd0, stall_o}, 32'd0);
    chk("stale_req", {31'd0, bus_req_o}, 32'd0);
    chk("stale_err", {31'd0, err_o}, 32'd0);
    chk("stale_rdata", mem_data_o, 32'd0);
    model_err = 1'b0;
    resp_en   = 1'b1;
    issue(1, 32'h400, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0, 1'b0);
    mon_en = 1'b0;

    repeat (3) @(negedge clk_i);
    chk("queues_drained", exp_q.size() + req_q.size() + plan_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
